// File: rtl/genesis_pad_pkg.sv
// Shared constants and types for the Genesis pad filter path.
// Bit order of the button word is {Z,Y,X,M,S,C,B,A,U,D,L,R}.
package genesis_pad_pkg;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_A = 4;
  localparam int unsigned BTN_B = 5;
  localparam int unsigned BTN_C = 6;
  localparam int unsigned BTN_S = 7;
  localparam int unsigned BTN_M = 8;
  localparam int unsigned BTN_X = 9;
  localparam int unsigned BTN_Y = 10;
  localparam int unsigned BTN_Z = 11;

  localparam logic [1:0] PAD_MS  = 2'd0;
  localparam logic [1:0] PAD_3B  = 2'd1;
  localparam logic [1:0] PAD_6B  = 2'd2;
  localparam logic [1:0] PAD_ERR = 2'd3;

  localparam logic [11:0] HOTKEY_MASK = 12'h0F0;

  typedef enum logic [1:0] {IDLE, COUNT, FIRED} hk_state_e;

  // Only a 6-button pad reports M/X/Y/Z; an errored pad reports nothing.
  function automatic logic [11:0] pad_mask(input logic [11:0] btn, input logic [1:0] pad_type);
    logic [11:0] w;
    w = btn;
    if (pad_type != PAD_6B) w[BTN_Z:BTN_M] = 4'h0;
    if (pad_type == PAD_ERR) w = '0;
    return w;
  endfunction

endpackage

// File: rtl/genesis_pad_tick.sv
// Free-running divider producing a one-clock tick every SAMPLE_DIV clocks.
module genesis_pad_tick #(
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 16'(SAMPLE_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/genesis_pad_filter.sv
// Debounce, pad-type masking, A/B/C turbo and Start+A+B+C long-press hotkey
// between the Genesis pad decoder and the core's joystick input.
module genesis_pad_filter
  import genesis_pad_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N   = 4,
  parameter int unsigned TURBO_HALF   = 33,
  parameter int unsigned HOLD_SAMPLES = 1000
) (
  input  logic        iCLK,
  input  logic        iN_RESET,
  input  logic [11:0] iGENPAD_DECODED,
  input  logic [1:0]  iGENPAD_TYPE,
  input  logic [2:0]  iTURBO_EN,
  output logic [11:0] oJOY,
  output logic        oJOY_STROBE,
  output logic        oHOTKEY
);

  logic        tick;
  logic [11:0] masked;
  logic        same;
  logic [4:0]  seen;
  logic        turbo_act;
  logic        combo;
  logic        fire;

  logic [11:0] samp_q, samp_d;
  logic [3:0]  stab_q, stab_d;
  logic [11:0] deb_q, deb_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        phase_q, phase_d;
  hk_state_e   hk_q, hk_d;
  logic [9:0]  hold_q, hold_d;
  logic [11:0] joy_q, joy_d;
  logic        strobe_q, strobe_d;
  logic        hot_q, hot_d;

  genesis_pad_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk_i (iCLK),
    .rst_ni(iN_RESET),
    .tick_o(tick)
  );

  assign masked    = pad_mask(iGENPAD_DECODED, iGENPAD_TYPE);
  assign same      = (masked == samp_q);
  // Number of consecutive ticks the current masked word has been seen, including this one.
  assign seen      = same ? {1'b0, stab_q} + 5'd1 : 5'd1;
  assign turbo_act = |(deb_q[BTN_C:BTN_A] & iTURBO_EN);
  assign combo     = ((deb_q & HOTKEY_MASK) == HOTKEY_MASK);

  always_comb begin
    samp_d = samp_q;
    stab_d = stab_q;
    deb_d  = deb_q;
    if (tick) begin
      if (!same) begin
        samp_d = masked;
        stab_d = 4'd1;
      end else if (stab_q < 4'(DEBOUNCE_N)) begin
        stab_d = stab_q + 4'd1;
      end
      if (seen >= 5'(DEBOUNCE_N)) deb_d = masked;
    end
  end

  // Held in the pressed phase while idle so a fresh turbo press shows up at once.
  always_comb begin
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    if (!turbo_act) begin
      tcnt_d  = 8'd0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (tcnt_q == 8'(TURBO_HALF - 1)) begin
        tcnt_d  = 8'd0;
        phase_d = ~phase_q;
      end else begin
        tcnt_d = tcnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    joy_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      if (iTURBO_EN[i]) joy_d[BTN_A+i] = deb_q[BTN_A+i] & phase_q;
    end
    strobe_d = (joy_d != joy_q);
  end

  always_comb begin
    hk_d   = hk_q;
    hold_d = hold_q;
    fire   = 1'b0;
    if (tick) begin
      unique case (hk_q)
        IDLE: begin
          if (combo) begin
            if (HOLD_SAMPLES == 1) begin
              hk_d = FIRED;
              fire = 1'b1;
            end else begin
              hk_d   = COUNT;
              hold_d = 10'd1;
            end
          end
        end
        COUNT: begin
          if (!combo) begin
            hk_d = IDLE;
          end else if (hold_q == 10'(HOLD_SAMPLES - 1)) begin
            hk_d = FIRED;
            fire = 1'b1;
          end else begin
            hold_d = hold_q + 10'd1;
          end
        end
        FIRED: begin
          if (!combo) hk_d = IDLE;
        end
        default: hk_d = IDLE;
      endcase
    end
    hot_d = fire;
  end

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      samp_q   <= '0;
      stab_q   <= '0;
      deb_q    <= '0;
      tcnt_q   <= '0;
      phase_q  <= 1'b1;
      hk_q     <= IDLE;
      hold_q   <= '0;
      joy_q    <= '0;
      strobe_q <= 1'b0;
      hot_q    <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      stab_q   <= stab_d;
      deb_q    <= deb_d;
      tcnt_q   <= tcnt_d;
      phase_q  <= phase_d;
      hk_q     <= hk_d;
      hold_q   <= hold_d;
      joy_q    <= joy_d;
      strobe_q <= strobe_d;
      hot_q    <= hot_d;
    end
  end

  assign oJOY        = joy_q;
  assign oJOY_STROBE = strobe_q;
  assign oHOTKEY     = hot_q;

endmodule

// File: tb/tb_genesis_pad_filter.sv
// Directed and randomized bench for genesis_pad_filter against a tick-level behavioural model.
module tb_genesis_pad_filter;

  localparam int unsigned DIV = 4;
  localparam int unsigned DN  = 3;
  localparam int unsigned TH  = 2;
  localparam int unsigned HS  = 5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pad   = 12'h000;
  logic [1:0]  ptype = 2'd0;
  logic [2:0]  ten   = 3'd0;
  logic [11:0] joy;
  logic        strobe;
  logic        hot;

  int checks = 0;
  int errors = 0;
  int hot_count = 0;
  int strobe_count = 0;

  // Model state: ticks-since-wrap, recent tick samples, debounced word,
  // ticks spent with turbo active, ticks the combo has been held.
  int          m_tick;
  logic [11:0] m_hist[$];
  logic [11:0] m_deb;
  int          m_active;
  int          m_run;
  logic [11:0] m_joy;
  logic        m_strobe;
  logic        m_hot;

  always #5 clk = ~clk;

  genesis_pad_filter #(
    .SAMPLE_DIV  (DIV),
    .DEBOUNCE_N  (DN),
    .TURBO_HALF  (TH),
    .HOLD_SAMPLES(HS)
  ) dut (
    .iCLK           (clk),
    .iN_RESET       (rst_n),
    .iGENPAD_DECODED(pad),
    .iGENPAD_TYPE   (ptype),
    .iTURBO_EN      (ten),
    .oJOY           (joy),
    .oJOY_STROBE    (strobe),
    .oHOTKEY        (hot)
  );

  function automatic logic [11:0] mask_of(input logic [11:0] w, input logic [1:0] t);
    if (t == 2'd3) return 12'h000;
    if (t != 2'd2) return {4'h0, w[7:0]};
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tick   = 0;
    m_hist.delete();
    m_deb    = 12'h000;
    m_active = 0;
    m_run    = 0;
    m_joy    = 12'h000;
    m_strobe = 1'b0;
    m_hot    = 1'b0;
  endtask

  // One rising clock edge with the inputs currently applied.
  task automatic model_step();
    logic        tk;
    logic        phase;
    logic        any;
    logic        cmb;
    logic [11:0] nj;
    logic [11:0] w;
    bit          all_same;
    tk     = (m_tick == int'(DIV) - 1);
    m_tick = tk ? 0 : m_tick + 1;
    phase  = ((m_active / int'(TH)) % 2) == 0;
    nj     = m_deb;
    for (int i = 0; i < 3; i++) if (ten[i]) nj[4+i] = m_deb[4+i] & phase;
    m_strobe = (nj != m_joy);
    m_joy    = nj;
    cmb      = ((m_deb & 12'h0F0) == 12'h0F0);
    any      = |(m_deb[6:4] & ten);
    m_hot    = 1'b0;
    if (!any) m_active = 0;
    else if (tk) m_active++;
    if (tk) begin
      if (cmb) begin
        m_run++;
        if (m_run == int'(HS)) m_hot = 1'b1;
      end else begin
        m_run = 0;
      end
      w = mask_of(pad, ptype);
      m_hist.push_back(w);
      if (m_hist.size() > int'(DN)) void'(m_hist.pop_front());
      all_same = (m_hist.size() == int'(DN));
      foreach (m_hist[k]) if (m_hist[k] != w) all_same = 0;
      if (all_same) m_deb = w;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check("joy", 32'(joy), 32'(m_joy));
    check("strobe", 32'(strobe), 32'(m_strobe));
    check("hotkey", 32'(hot), 32'(m_hot));
    if (hot) hot_count++;
    if (strobe) strobe_count++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asynchronous assertion away from any clock edge, release on a falling edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("rst_joy", 32'(joy), 32'h0);
    check("rst_strobe", 32'(strobe), 32'h0);
    check("rst_hotkey", 32'(hot), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          sc;
    int          hc;
    bit          found;
    logic [7:0]  pat;
    logic [11:0] words[8];
    model_reset();
    words[0] = 12'h000; words[1] = 12'h0F0; words[2] = 12'h0F1; words[3] = 12'h010;
    words[4] = 12'h810; words[5] = 12'hF01; words[6] = 12'h070; words[7] = 12'h0F0;

    // Reset state, then 12'h810 on a 6-button pad from release onward.
    @(negedge clk);
    check("reset_joy", 32'(joy), 32'h0);
    check("reset_strobe", 32'(strobe), 32'h0);
    ptype = 2'd2;
    pad   = 12'h810;
    @(negedge clk);
    rst_n = 1'b1;
    sc = strobe_count;
    run(12);
    check("deb_before_3rd_tick", 32'(joy), 32'h0);
    run(1);
    check("deb_after_3rd_tick", 32'(joy), 32'h810);
    check("deb_strobe", 32'(strobe), 32'h1);
    run(1);
    check("deb_single_strobe", 32'(strobe_count - sc), 32'd1);

    // One-tick glitch is rejected.
    sc  = strobe_count;
    pad = 12'h010;
    run(2);
    pad = 12'h810;
    run(16);
    check("glitch_joy", 32'(joy), 32'h810);
    check("glitch_no_strobe", 32'(strobe_count - sc), 32'd0);

    // Type masking.
    ptype = 2'd1;
    pad   = 12'hF01;
    run(20);
    check("type3b_joy", 32'(joy), 32'h001);
    ptype = 2'd3;
    pad   = 12'hFFF;
    run(20);
    check("typeerr_joy", 32'(joy), 32'h000);

    // Turbo on A: two ticks pressed, two released, repeating.
    ptype = 2'd2;
    ten   = 3'b001;
    pad   = 12'h010;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (joy[4]) found = 1;
    end
    check("turbo_start", 32'(found), 32'h1);
    pat = 8'b0011_0011;
    for (int j = 0; j < 8; j++) begin
      check("turbo_bit4", 32'(joy[4]), 32'(pat[j]));
      run(4);
    end
    pad = 12'h000;
    run(20);
    check("turbo_release", 32'(joy), 32'h000);

    // Hotkey: one pulse per hold, re-arms after release.
    ten = 3'b000;
    hc  = hot_count;
    pad = 12'h0F0;
    run(120);
    check("hotkey_once", 32'(hot_count - hc), 32'd1);
    pad = 12'h000;
    run(20);
    pad = 12'h0F0;
    run(28);
    check("hotkey_rearm_early", 32'(hot_count - hc), 32'd1);
    run(8);
    check("hotkey_rearm", 32'(hot_count - hc), 32'd2);

    // Interrupted hold restarts the count.
    pad = 12'h000;
    run(24);
    hc  = hot_count;
    pad = 12'h0F0;
    run(12);
    pad = 12'h000;
    run(12);
    pad = 12'h0F0;
    run(28);
    check("hold_restart_early", 32'(hot_count - hc), 32'd0);
    run(8);
    check("hold_restart_fire", 32'(hot_count - hc), 32'd1);

    // Reset mid-operation.
    do_reset();
    run(3);

    // Randomized segments.
    repeat (300) begin
      pad = ($urandom_range(0, 4) == 0) ? 12'($urandom) : words[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0) ptype = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd2;
      if ($urandom_range(0, 3) == 0) ten = 3'($urandom);
      if ($urandom_range(0, 40) == 0) do_reset();
      run($urandom_range(1, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
